// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default frame constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int OSR_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT = 8;
endpackage

// File: rtl/rx_sync2.sv
// rx_sync2: two-flop synchronizer with a selectable reset level
module rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // bring the asynchronous line into the clk domain
    always_ff @(posedge clk)
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/oversample_rx.sv
// oversample_rx: oversampling serial receiver with 3-sample majority vote per bit
module oversample_rx
    import uart_pkg::*;
#(
    parameter int OSR = OSR_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter bit PARITY_EN = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 bit_strobe,
    output logic                 busy
);
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] S_LO = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] S_MID = CW'(OSR / 2);
    localparam logic [CW-1:0] S_HI = CW'(OSR / 2 + 1);
    localparam logic [CW-1:0] S_LAST = CW'(OSR - 1);

    if (OSR < 4) begin : g_osr_check
        $error("oversample_rx: OSR must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
        $error("oversample_rx: DATA_BITS must be 5..9");
    end

    rx_state_t            state;
    logic                 rx_s;
    logic                 s_lo;
    logic                 s_mid;
    logic                 par_bit;
    logic [CW-1:0]        cnt;
    logic [3:0]           nbits;
    logic [DATA_BITS-1:0] shreg;
    logic                 decide;
    logic                 last;
    logic                 vote;

    rx_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(rx_in),
        .q(rx_s)
    );

    // the third vote sample is the live synchronized line on the deciding tick
    assign decide = sample_tick && state != IDLE && cnt == S_HI;
    assign last = cnt == S_LAST;
    assign vote = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign busy = state != IDLE;

    // frame sequencing, sample capture and registered result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            nbits <= '0;
            shreg <= '0;
            s_lo <= 1'b1;
            s_mid <= 1'b1;
            par_bit <= 1'b0;
            data_out <= '0;
            data_valid <= 1'b0;
            frame_err <= 1'b0;
            parity_err <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err <= 1'b0;
            parity_err <= 1'b0;
            bit_strobe <= decide;
            if (sample_tick && state == IDLE) begin
                if (!rx_s) begin
                    state <= START;
                    cnt <= CW'(1);
                end
            end else if (sample_tick) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (cnt == S_LO) s_lo <= rx_s;
                if (cnt == S_MID) s_mid <= rx_s;
                case (state)
                    START: begin
                        if (decide && vote) begin
                            state <= IDLE;
                            cnt <= '0;
                        end else if (last) begin
                            state <= DATA;
                            nbits <= '0;
                        end
                    end
                    DATA: begin
                        if (decide) begin
                            shreg <= {vote, shreg[DATA_BITS-1:1]};
                            nbits <= nbits + 1'b1;
                        end
                        if (last && nbits == 4'(DATA_BITS)) state <= PARITY_EN ? PARITY : STOP;
                    end
                    PARITY: begin
                        if (decide) par_bit <= vote;
                        if (last) state <= STOP;
                    end
                    STOP: begin
                        if (decide) begin
                            state <= IDLE;
                            cnt <= '0;
                            data_out <= shreg;
                            data_valid <= 1'b1;
                            frame_err <= !vote;
                            parity_err <= PARITY_EN && (^shreg ^ par_bit ^ PARITY_ODD);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/oversample_rx.md
OVERSAMPLE_RX -- requirements
Module: oversample_rx

Interface
REQ-001 Parameter OSR, default 16, meaning samples per bit; SHALL be at least 4, and elaboration SHALL fail otherwise.
REQ-002 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0, meaning 1 inserts one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, meaning 1 selects odd parity and 0 selects even; ignored when PARITY_EN=0.
REQ-005 Port clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port sample_tick  input  1  oversample strobe; one tick equals one sample period.
REQ-008 Port rx_in  input  1  asynchronous serial line, idle high.
REQ-009 Port data_out  output  DATA_BITS  last received word, LSB received first.
REQ-010 Port data_valid  output  1  one-cycle pulse; data_out is new this cycle.
REQ-011 Port frame_err  output  1  one-cycle pulse with data_valid when the stop bit is sampled as 0.
REQ-012 Port parity_err  output  1  one-cycle pulse with data_valid when parity mismatches.
REQ-013 Port bit_strobe  output  1  one-cycle pulse at each bit decision (start, data, parity, stop).
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 rx_in SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-016 The states SHALL be IDLE, START, DATA, PARITY and STOP; PARITY is skipped when PARITY_EN=0.
REQ-017 The sample counter, width clog2(OSR), SHALL advance only on sample_tick and wrap from OSR-1 to 0 at each bit boundary.
REQ-018 In IDLE, a tick with rx_s=0 SHALL enter START with the counter at 0 for that tick.
REQ-019 Each bit's value SHALL be the majority of rx_s at counter values OSR/2-1, OSR/2 and OSR/2+1 (integer division), decided at tick OSR/2+1.
REQ-020 bit_strobe SHALL pulse in the cycle after the deciding tick.
REQ-021 In START, a vote of 1 SHALL be treated as a false start: return to IDLE with no outputs other than bit_strobe.
REQ-022 In DATA, bits SHALL shift in LSB-first; after DATA_BITS decisions the FSM moves to PARITY or STOP at the next bit boundary.
REQ-023 In PARITY, parity_err SHALL be computed as data bits XOR parity bit XOR PARITY_ODD, nonzero meaning error.
REQ-024 In STOP, on the deciding tick the FSM SHALL update data_out and pulse data_valid in the following cycle, together with frame_err and parity_err as applicable.
REQ-025 After the STOP decision the FSM SHALL go to IDLE immediately, without waiting for the end of the stop bit, so back-to-back frames are accepted.
REQ-026 A frame_err frame SHALL still update data_out and pulse data_valid.
REQ-027 Cycles without sample_tick SHALL hold all state; with a tick every cycle, a frame completes in (1+DATA_BITS+PARITY_EN)*OSR + OSR/2+2 ticks plus 1 cycle.
REQ-028 rx_s transitions during IDLE with no tick SHALL NOT start a frame.

Reset
REQ-029 While rst=1 at a rising clk edge: FSM to IDLE, counter 0, shift register 0, synchronizer flops 1.
REQ-030 Reset outputs SHALL be data_out=0, data_valid=0, frame_err=0, parity_err=0, bit_strobe=0, busy=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no data_valid; the next falling edge after release starts a fresh frame.

Structure
REQ-032 Package uart_pkg SHALL hold the rx_state_t enum and default constants (OSR_DEFAULT=16, DATA_BITS_DEFAULT=8).
REQ-033 The synchronizer SHALL be a sub-module rx_sync2, with a parameterised reset value of 1.
REQ-034 The majority vote SHALL be implemented inline, as 3 sample registers plus a combinational vote.

Verification (OSR=16, DATA_BITS=8, tick every cycle unless stated)
REQ-035 Frame 0xA5 with a good stop bit -> data_out=0xA5, one data_valid pulse, frame_err=0, 10 bit_strobe pulses.
REQ-036 Low glitch of 4 ticks in IDLE -> start vote 1, return to IDLE, no data_valid, busy low within 10 ticks.
REQ-037 0x3C with stop bit 0 -> data_valid and frame_err pulse in the same cycle, data_out=0x3C.
REQ-038 PARITY_EN=1, PARITY_ODD=0, 0x07 sent with parity bit 0 -> parity_err=1 with data_valid; parity bit 1 -> parity_err=0.
REQ-039 rx_in forced high at sample OSR/2 only of bit 3, with bit value 0 -> the majority still yields 0, so data_out is unaffected.
REQ-040 rst asserted at bit 4 of frame 0x55, then 0xC3 sent -> no pulse for 0x55, data_out=0xC3; the same scenario repeated with a tick every 3rd cycle gives the same result.
